// File: rtl/sa_cache_pkg.sv
// sa_cache_pkg: shared state encoding, line layout and width helpers for the two-way cache.
package sa_cache_pkg;
  localparam int TAG_MAX = 64;
  localparam int DATA_MAX = 64;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM} state_t;
  // Fields sized for the widest supported configuration so one layout serves every instance.
  typedef struct packed {
    logic valid;
    logic [TAG_MAX-1:0] tag;
    logic [DATA_MAX-1:0] data;
  } cache_line_t;
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - 2 - $clog2(sets);
  endfunction
endpackage

// File: rtl/sa_cache_way.sv
// sa_cache_way: one way of the cache - line storage with a write port and combinational lookup.
module sa_cache_way
  import sa_cache_pkg::*;
#(
  parameter int SETS = 8,
  parameter int TAG_W = 27,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [$clog2(SETS)-1:0] idx,
  input logic [TAG_W-1:0] tag,
  input logic [DATA_WIDTH-1:0] wr_data,
  output logic valid,
  output logic hit,
  output logic [DATA_WIDTH-1:0] rd_data
);
  cache_line_t lines [SETS];
  always_ff @(posedge clk or posedge rst)
    if (rst) lines <= '{default: '0};
    else if (we) lines[idx] <= '{valid: 1'b1, tag: TAG_MAX'(tag), data: DATA_MAX'(wr_data)};
  assign valid = lines[idx].valid;
  assign hit = valid && lines[idx].tag == TAG_MAX'(tag);
  assign rd_data = DATA_WIDTH'(lines[idx].data);
endmodule

// File: rtl/sa_cache.sv
// sa_cache: two-way set-associative write-through, no-write-allocate cache with per-set LRU,
// blocking miss/write FSM toward a req/ack memory, and saturating hit/miss counters.
module sa_cache
  import sa_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS = 8,
  parameter int COUNT_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  input logic cpu_read_en,
  input logic cpu_write_en,
  input logic [ADDR_WIDTH-1:0] cpu_addr,
  input logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic cpu_stall,
  output logic mem_req,
  output logic mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input logic [DATA_WIDTH-1:0] mem_read_data,
  input logic mem_ack,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_WIDTH, SETS);
  state_t state, next_state;
  logic [SETS-1:0] lru;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [DATA_WIDTH-1:0] data0, data1, wr_data;
  logic hit0, hit1, valid0, valid1, we0, we1, victim, reading, access, hit, ack;
  assign idx = cpu_addr[IDX_W+1:2];
  assign tag = cpu_addr[ADDR_WIDTH-1:IDX_W+2];
  assign reading = cpu_read_en & ~cpu_write_en;
  assign access = state == IDLE && (cpu_read_en || cpu_write_en);
  assign hit = hit0 | hit1;
  assign ack = mem_req & mem_ack;
  // Empty ways fill before LRU is consulted, way 0 first.
  assign victim = ~valid0 ? 1'b0 : ~valid1 ? 1'b1 : lru[idx];
  assign wr_data = state == REFILL ? mem_read_data : cpu_write_data;
  sa_cache_way #(.SETS(SETS), .TAG_W(TAG_W), .DATA_WIDTH(DATA_WIDTH)) u_way0 (
    .clk(clk), .rst(rst), .we(we0), .idx(idx), .tag(tag), .wr_data(wr_data),
    .valid(valid0), .hit(hit0), .rd_data(data0)
  );
  sa_cache_way #(.SETS(SETS), .TAG_W(TAG_W), .DATA_WIDTH(DATA_WIDTH)) u_way1 (
    .clk(clk), .rst(rst), .we(we1), .idx(idx), .tag(tag), .wr_data(wr_data),
    .valid(valid1), .hit(hit1), .rd_data(data1)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = state == IDLE ? (cpu_write_en ? WRITE_MEM : reading && !hit ? REFILL : IDLE)
                               : ack ? IDLE : state;
  always_comb begin
    cpu_stall = !rst && (state == IDLE ? cpu_write_en || (reading && !hit) : !ack);
    cpu_read_data = rst ? '0
                  : state == REFILL && ack ? mem_read_data
                  : state == IDLE && reading && hit ? (hit0 ? data0 : data1) : '0;
    we0 = state == REFILL ? ack & ~victim : state == IDLE && cpu_write_en && hit0;
    we1 = state == REFILL ? ack & victim : state == IDLE && cpu_write_en && hit1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_write_data <= '0;
      lru <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (access) begin
        hit_count <= hit_count + COUNT_WIDTH'(hit && !(&hit_count));
        miss_count <= miss_count + COUNT_WIDTH'(!hit && !(&miss_count));
        if (hit) lru[idx] <= hit0;
        if (cpu_write_en || !hit) begin
          mem_req <= 1'b1;
          mem_we <= cpu_write_en;
          mem_addr <= cpu_addr & ~ADDR_WIDTH'(3);
        end
        if (cpu_write_en) mem_write_data <= cpu_write_data;
      end
      if (state == REFILL && ack) lru[idx] <= ~victim;
      if (ack) mem_req <= 1'b0;
    end
endmodule

// File: tb/tb_sa_cache.sv
// tb_sa_cache: directed and random accesses checked against a recency-queue model of the cache.
module tb_sa_cache;
  logic clk = 0, rst = 1, cpu_read_en = 0, cpu_write_en = 0, mem_ack = 0;
  logic [31:0] cpu_addr = '0, cpu_write_data = '0, mem_read_data = '0;
  logic [31:0] cpu_read_data, mem_addr, mem_write_data;
  logic cpu_stall, mem_req, mem_we;
  logic [3:0] hit_count, miss_count;
  int n_chk = 0, n_err = 0;
  int m_hits = 0, m_misses = 0;
  logic [31:0] line_data [int];
  int order [8][$];
  logic [31:0] mem [int];
  always #5 clk = ~clk;
  sa_cache #(.COUNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void touch(input int wa);
    int s = wa % 8;
    for (int i = 0; i < order[s].size(); i++)
      if (order[s][i] == wa) begin
        order[s].delete(i);
        break;
      end
    order[s].push_back(wa);
  endfunction
  function automatic void install(input int wa, input logic [31:0] d);
    int s = wa % 8;
    if (order[s].size() == 2) begin
      int v = order[s].pop_front();
      line_data.delete(v);
    end
    order[s].push_back(wa);
    line_data[wa] = d;
  endfunction
  function automatic void model_reset();
    line_data.delete();
    for (int s = 0; s < 8; s++) order[s].delete();
    m_hits = 0;
    m_misses = 0;
  endfunction
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd, input int n);
    int wa = int'(a >> 2);
    bit h = line_data.exists(wa);
    logic [31:0] rv;
    if (rd && !wr && !mem.exists(wa)) mem[wa] = $urandom;
    rv = (rd && !wr) ? mem[wa] : $urandom;
    cpu_read_en = rd;
    cpu_write_en = wr;
    cpu_addr = a;
    cpu_write_data = wd;
    @(negedge clk);
    if (rd && !wr && h) begin
      chk("hit_stall", cpu_stall, 0);
      chk("hit_data", cpu_read_data, line_data[wa]);
      touch(wa);
    end else begin
      chk("req_stall", cpu_stall, 1);
      chk("req_rdata", cpu_read_data, 0);
      @(posedge clk); #1;
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, wr);
      chk("mem_addr", mem_addr, a & ~32'h3);
      if (wr) chk("mem_wdata", mem_write_data, wd);
      repeat (n) begin
        @(negedge clk);
        chk("wait_stall", cpu_stall, 1);
        @(posedge clk); #1;
      end
      mem_ack = 1;
      mem_read_data = rv;
      @(negedge clk);
      chk("ack_stall", cpu_stall, 0);
      chk("ack_rdata", cpu_read_data, (rd && !wr) ? rv : 32'h0);
      if (wr) begin
        mem[wa] = wd;
        if (h) begin
          line_data[wa] = wd;
          touch(wa);
        end
      end else install(wa, rv);
    end
    if (h) m_hits += (m_hits < 15) ? 1 : 0;
    else m_misses += (m_misses < 15) ? 1 : 0;
    @(posedge clk); #1;
    mem_ack = 0;
    cpu_read_en = 0;
    cpu_write_en = 0;
    chk("mem_req_low", mem_req, 0);
    chk("hits", hit_count, m_hits);
    chk("misses", miss_count, m_misses);
  endtask
  initial begin
    cpu_read_en = 1;
    cpu_addr = 32'h100;
    #2;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rdata", cpu_read_data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    @(posedge clk); #1;
    rst = 0;
    cpu_read_en = 0;
    model_reset();
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    access(1, 0, 32'h100, 0, 3);
    access(1, 0, 32'h100, 0, 0);
    mem_ack = 1;
    @(negedge clk);
    chk("stray_ack_stall", cpu_stall, 0);
    @(posedge clk); #1;
    mem_ack = 0;
    chk("stray_ack_req", mem_req, 0);
    access(1, 0, 32'h200, 0, 1);
    access(1, 0, 32'h200, 0, 0);
    access(1, 0, 32'h300, 0, 2);
    access(1, 0, 32'h100, 0, 0);
    access(1, 0, 32'h300, 0, 0);
    access(0, 1, 32'h200, 32'h12345678, 1);
    access(1, 0, 32'h200, 0, 0);
    access(1, 0, 32'h100, 0, 0);
    access(0, 1, 32'h100, 32'hA5A5A5A5, 0);
    access(1, 0, 32'h100, 0, 0);
    access(0, 1, 32'h400, 32'h0BADF00D, 2);
    access(1, 0, 32'h400, 0, 1);
    cpu_read_en = 1;
    cpu_addr = 32'h500;
    @(posedge clk); #1;
    chk("refill_req_up", mem_req, 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("abort_req_drop", mem_req, 0);
    chk("abort_stall", cpu_stall, 0);
    chk("abort_hits", hit_count, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    cpu_read_en = 0;
    access(1, 0, 32'h500, 0, 2);
    access(1, 0, 32'h700, 0, 0);
    repeat (20) access(1, 0, 32'h700, 0, 0);
    access(1, 1, 32'h600, 32'hCAFEF00D, 1);
    repeat (80) begin
      int kind = $urandom_range(0, 3);
      logic [31:0] a = ($urandom_range(0, 5) << 5) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      access(kind != 2, kind >= 2, a, $urandom, $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sa_cache.md
# sa_cache

Parametrised two-way set-associative, write-through, no-write-allocate data cache with per-set LRU replacement, a blocking miss/refill state machine and hit/miss counters. Sits between the CPU load/store stage and data memory as the successor to the direct-mapped cache: the CPU side sees single-cycle hits and a stall on misses and writes, and the memory side uses a req/ack handshake.

## Interface
- ADDR_WIDTH, 32: byte-address width.
- DATA_WIDTH, 32: word width; one word per line.
- SETS, 8: number of sets; power of two, ≥2. IDX_W = log2(SETS); TAG_W = ADDR_WIDTH-2-IDX_W.
- COUNT_WIDTH, 32: hit/miss counter width.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_read_en  in  1  load request; held with address stable while cpu_stall=1.
- cpu_write_en  in  1  store request; held with address and data stable while cpu_stall=1.
- cpu_addr  in  ADDR_WIDTH  byte address; [1:0] ignored, index = [IDX_W+1:2], tag = [ADDR_WIDTH-1:IDX_W+2].
- cpu_write_data  in  DATA_WIDTH  store data.
- cpu_read_data  out  DATA_WIDTH  load data, valid when cpu_read_en=1 and cpu_stall=0.
- cpu_stall  out  1  CPU must hold its request.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, 0 = read; registered.
- mem_addr  out  ADDR_WIDTH  word-aligned ({cpu_addr[ADDR_WIDTH-1:2],2'b00}); registered.
- mem_write_data  out  DATA_WIDTH  registered.
- mem_read_data  in  DATA_WIDTH  valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse; meaningful only while mem_req=1.
- hit_count, miss_count  out  COUNT_WIDTH  saturating access counters.

## Operation
- Per set and way: valid, tag, data. Per set: one LRU bit naming the way to evict.
- States: IDLE, REFILL, WRITE_MEM.
- IDLE with read hit: cpu_read_data = hit way data (combinational), cpu_stall=0, and LRU is set to the other way at the edge.
- IDLE with read miss: cpu_stall=1. At the edge: mem_req=1, mem_we=0, mem_addr latched; go to REFILL.
- REFILL: cpu_stall=1 until mem_ack. In the ack cycle: cpu_read_data = mem_read_data, cpu_stall=0. At that edge, install valid/tag/data into the way selected by LRU (an invalid way takes priority, way 0 first), flip LRU away from that way, drop mem_req, and return to IDLE.
- IDLE with write: cpu_stall=1. At the edge: on a hit, update the hit way's data and LRU; on a miss, do not allocate. Register mem_req=1, mem_we=1, mem_addr and mem_write_data; go to WRITE_MEM.
- WRITE_MEM: cpu_stall=1 except in the mem_ack cycle. At the ack edge, drop mem_req and return to IDLE.
- cpu_read_en and cpu_write_en both high: treated as a write; cpu_read_data = 0.
- No request, or not a hit outside the REFILL ack cycle: cpu_read_data = 0.
- Counters increment once per access, on its first IDLE cycle only (a write hit counts as a hit). They saturate at all-ones.
- mem_ack while mem_req=0 is ignored.

## Timing
- Reset values: state IDLE, all valid and LRU bits 0, mem_req 0, mem_we 0, mem_addr 0, mem_write_data 0, counters 0. cpu_stall is 0 and cpu_read_data is 0 while rst is high.
- Read hit: 0 stall cycles.
- Read miss: request cycle, then mem_req high from the next cycle. If ack arrives N cycles after mem_req rises (N≥0), the total is N+2 cycles including the ack cycle.
- Writes: same latency as a read miss.
- Reset mid-REFILL or mid-WRITE_MEM: mem_req falls immediately (asynchronous) and the transaction is abandoned. No line is installed.

## Structure
- Package sa_cache_pkg: state enum, the cache_line_t struct (valid, tag, data), and width helper functions (IDX_W, TAG_W).
- Sub-module sa_cache_way: one way's storage array (valid/tag/data, write port, combinational lookup returning hit and data). It is instantiated twice. The FSM, LRU bits and counters live in the top module.

## Test plan
- Reset; read 0x100 → miss, mem_req with mem_addr 0x100, mem_we=0. Ack 3 cycles later with 0xDEADBEEF → cpu_read_data 0xDEADBEEF in the ack cycle. Re-read 0x100 → hit, no stall; hit_count=1, miss_count=1.
- With SETS=8, fill 0x100 and 0x200 (same index 0), then read 0x200 → hit. Read 0x300 → miss, evicts 0x100. Read 0x100 → miss; read 0x300 → hit.
- Write 0x200 with 0x12345678 → mem_we=1, mem_write_data 0x12345678. After ack, read 0x200 → hit returning 0x12345678. Write 0x400 (miss), then read 0x400 → miss (no allocate).
- Assert rst two cycles into a REFILL of 0x500 → mem_req=0 at once. Read 0x500 → miss again.
- COUNT_WIDTH=4: 20 read hits → hit_count=15.
- cpu_read_en=cpu_write_en=1 at 0x600 → write transaction on memory, cpu_read_data=0.
